// File: rtl/sfx_pkg.sv
// -----------------------------------------------------------------------------
// sfx_pkg
// Shared types and constants for the sound-effect tone generator.
//   sfx_state_t      : burst FSM state (IDLE / PLAY)
//   EVT_*            : event channel indices; a lower index has higher priority
//   DEF_PERIOD_* /
//   DEF_DUR_*        : suggested half-period (clk cycles) and burst length
//                      (half-periods) per event, for the game FSM to drive
// -----------------------------------------------------------------------------
package sfx_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } sfx_state_t;

    localparam int unsigned EVT_BAD      = 32'd0;
    localparam int unsigned EVT_GAMEOVER = 32'd1;
    localparam int unsigned EVT_GOOD     = 32'd2;
    localparam int unsigned EVT_FOOD     = 32'd3;

    // Low pitch for bad news, high pitch for rewards.
    localparam logic [15:0] DEF_PERIOD_BAD      = 16'd40000;
    localparam logic [15:0] DEF_PERIOD_GAMEOVER = 16'd50000;
    localparam logic [15:0] DEF_PERIOD_GOOD     = 16'd12500;
    localparam logic [15:0] DEF_PERIOD_FOOD     = 16'd8000;

    localparam logic [11:0] DEF_DUR_BAD         = 12'd120;
    localparam logic [11:0] DEF_DUR_GAMEOVER    = 12'd600;
    localparam logic [11:0] DEF_DUR_GOOD        = 12'd200;
    localparam logic [11:0] DEF_DUR_FOOD        = 12'd160;

endpackage

// File: rtl/sfx_evt_arb.sv
// -----------------------------------------------------------------------------
// sfx_evt_arb
// Rising-edge detection and fixed-priority arbitration of the event lines.
//   clk, rst    : clock, asynchronous active-high reset
//   evt         : raw event request levels
//   busy        : a burst is currently playing
//   active_evt  : index of the playing event
//   start       : accepted trigger this cycle (start or restart a burst)
//   start_idx   : index of the winning trigger (valid with start)
//   dropped     : registered one-cycle pulse when any trigger is discarded
// -----------------------------------------------------------------------------
module sfx_evt_arb
#(
    parameter int NUM_EVT = 4,
    parameter int IDX_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               busy,
    input  logic [IDX_W-1:0]   active_evt,
    output logic               start,
    output logic [IDX_W-1:0]   start_idx,
    output logic               dropped
);

    localparam logic [NUM_EVT-1:0] TRIG_ONE = {{(NUM_EVT-1){1'b0}}, 1'b1};

    logic [NUM_EVT-1:0] evt_q_r;
    logic [NUM_EVT-1:0] trig_s;
    logic               any_s;
    logic               multi_s;
    logic [IDX_W-1:0]   idx_s;
    logic               accept_s;
    logic               lose_s;
    logic               dropped_r;

    // Previous event levels; cleared by reset so a line high at release triggers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_q_r <= '0;
        end else begin
            evt_q_r <= evt;
        end
    end

    // Edge detect, lowest-index-wins encoder and accept/discard decision.
    always_comb begin
        trig_s  = evt & ~evt_q_r;
        any_s   = |trig_s;
        // Clearing the lowest set bit leaves something only if >1 bit was set.
        multi_s = |(trig_s & (trig_s - TRIG_ONE));
        idx_s   = '0;
        for (int k = NUM_EVT - 1; k >= 0; k--) begin
            if (trig_s[k]) begin
                idx_s = IDX_W'(k);
            end else begin
                idx_s = idx_s;
            end
        end
        // A playing burst yields only to an equal or higher-priority event.
        accept_s = any_s && (!busy || (idx_s <= active_evt));
        lose_s   = multi_s || (any_s && busy && (idx_s > active_evt));
    end

    // Discard notification pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropped_r <= 1'b0;
        end else begin
            dropped_r <= lose_s;
        end
    end

    assign start     = accept_s;
    assign start_idx = idx_s;
    assign dropped   = dropped_r;

endmodule

// File: rtl/sfx_tone_gen.sv
// -----------------------------------------------------------------------------
// sfx_tone_gen
// Multi-channel sound-effect tone generator: one square-wave burst at a time,
// chosen by fixed priority among rising event edges.
//   clk, rst      : clock, asynchronous active-high reset
//   evt_i         : event request levels, 0->1 triggers
//   period_i      : per-event half-period in clk cycles (slice k = event k)
//   dur_i         : per-event burst length in half-periods
//   sweep_i       : per-event pitch-sweep enable
//   square_o      : speaker tone
//   at_max_o      : half-period terminal-count tick
//   busy_o        : burst playing
//   active_evt_o  : playing event index, 0 when idle
//   done_o        : pulse after a burst completes normally
//   dropped_o     : pulse when a trigger is discarded
// Build option: SFX_SWEEP_EN adds a saturating downward pitch sweep; without
// it sweep_i and SWEEP_SHIFT have no effect.
// -----------------------------------------------------------------------------
module sfx_tone_gen
#(
    parameter int NUM_EVT     = 4,
    parameter int DIV_W       = 16,
    parameter int DUR_W       = 12,
    parameter int SWEEP_SHIFT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_EVT-1:0]         evt_i,
    input  logic [NUM_EVT*DIV_W-1:0]   period_i,
    input  logic [NUM_EVT*DUR_W-1:0]   dur_i,
    input  logic [NUM_EVT-1:0]         sweep_i,
    output logic                       square_o,
    output logic                       at_max_o,
    output logic                       busy_o,
    output logic [$clog2(NUM_EVT)-1:0] active_evt_o,
    output logic                       done_o,
    output logic                       dropped_o
);
    import sfx_pkg::*;

    localparam int IDX_W = $clog2(NUM_EVT);
    localparam logic [DIV_W-1:0] PER_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] PER_MIN = {{(DIV_W-2){1'b0}}, 2'b10};
    localparam logic [DUR_W-1:0] DUR_ONE = {{(DUR_W-1){1'b0}}, 1'b1};

    sfx_state_t       state_r;
    sfx_state_t       state_nxt_s;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] period_r;
    logic [DUR_W-1:0] dur_rem_r;
    logic [IDX_W-1:0] active_r;
    logic             square_r;
    logic             done_r;
    logic             start_s;
    logic [IDX_W-1:0] start_idx_s;
    logic             dropped_s;
    logic             playing_s;
    logic             at_max_s;
    logic             last_s;
    logic [DIV_W-1:0] sel_period_s;
    logic [DIV_W-1:0] load_period_s;
    logic [DUR_W-1:0] sel_dur_s;
    logic [DUR_W-1:0] load_dur_s;

    sfx_evt_arb #(
        .NUM_EVT (NUM_EVT),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .evt        (evt_i),
        .busy       (playing_s),
        .active_evt (active_r),
        .start      (start_s),
        .start_idx  (start_idx_s),
        .dropped    (dropped_s)
    );

    // Terminal count and last-half-period detection from registered state.
    always_comb begin
        playing_s = (state_r == PLAY);
        at_max_s  = playing_s && (cnt_r == (period_r - PER_ONE));
        last_s    = at_max_s && (dur_rem_r == DUR_ONE);
    end

    // Parameters of the winning event, clamped to period >= 2 and dur >= 1.
    always_comb begin
        sel_period_s = period_i[int'(start_idx_s)*DIV_W +: DIV_W];
        sel_dur_s    = dur_i[int'(start_idx_s)*DUR_W +: DUR_W];
        if (sel_period_s < PER_MIN) begin
            load_period_s = PER_MIN;
        end else begin
            load_period_s = sel_period_s;
        end
        if (sel_dur_s == '0) begin
            load_dur_s = DUR_ONE;
        end else begin
            load_dur_s = sel_dur_s;
        end
    end

`ifdef SFX_SWEEP_EN
    logic             sweep_r;
    logic [DIV_W-1:0] shr_s;
    logic [DIV_W-1:0] step_s;
    logic [DIV_W:0]   sum_s;
    logic [DIV_W-1:0] swept_s;

    // Next period for a sweeping burst: grow by period>>SHIFT (min 1), saturating.
    always_comb begin
        shr_s = period_r >> SWEEP_SHIFT;
        if (shr_s == '0) begin
            step_s = PER_ONE;
        end else begin
            step_s = shr_s;
        end
        sum_s = {1'b0, period_r} + {1'b0, step_s};
        if (sum_s[DIV_W]) begin
            swept_s = {DIV_W{1'b1}};
        end else begin
            swept_s = sum_s[DIV_W-1:0];
        end
    end

    // Sweep enable captured at burst start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_r <= 1'b0;
        end else if (start_s) begin
            sweep_r <= sweep_i[start_idx_s];
        end else begin
            sweep_r <= sweep_r;
        end
    end
`else
    logic unused_sweep_s;
    assign unused_sweep_s = ^{sweep_i, (SWEEP_SHIFT > 0)};
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: any accepted trigger (re)starts, last half-period ends.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nxt_s = PLAY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PLAY: begin
                if (start_s) begin
                    state_nxt_s = PLAY;
                end else if (last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = PLAY;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Tone datapath: load on (re)start, count half-periods while playing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= '0;
            period_r  <= '0;
            dur_rem_r <= '0;
            active_r  <= '0;
            square_r  <= 1'b0;
        end else if (start_s) begin
            cnt_r     <= '0;
            period_r  <= load_period_s;
            dur_rem_r <= load_dur_s;
            active_r  <= start_idx_s;
            square_r  <= 1'b0;
        end else if (playing_s) begin
            if (at_max_s) begin
                cnt_r <= '0;
                if (last_s) begin
                    dur_rem_r <= '0;
                    active_r  <= '0;
                    square_r  <= 1'b0;
                end else begin
                    dur_rem_r <= dur_rem_r - DUR_ONE;
                    active_r  <= active_r;
                    square_r  <= ~square_r;
                end
`ifdef SFX_SWEEP_EN
                if (sweep_r) begin
                    period_r <= swept_s;
                end else begin
                    period_r <= period_r;
                end
`endif
            end else begin
                cnt_r <= cnt_r + PER_ONE;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Completion pulse; a burst cut short by a restart does not report done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_r <= 1'b0;
        end else begin
            done_r <= last_s && !start_s;
        end
    end

    assign square_o     = square_r;
    assign at_max_o     = at_max_s;
    assign busy_o       = playing_s;
    assign active_evt_o = active_r;
    assign done_o       = done_r;
    assign dropped_o    = dropped_s;

endmodule

// File: tb/tb_sfx_tone_gen.sv
module tb_sfx_tone_gen;

    localparam int NUM_EVT     = 4;
    localparam int DIV_W       = 16;
    localparam int DUR_W       = 12;
    localparam int SWEEP_SHIFT = 3;

    logic                     tb_clk = 1'b0;
    logic                     rst;
    logic [NUM_EVT-1:0]       evt_i;
    logic [NUM_EVT*DIV_W-1:0] period_i;
    logic [NUM_EVT*DUR_W-1:0] dur_i;
    logic [NUM_EVT-1:0]       sweep_i;
    logic                     square_o;
    logic                     at_max_o;
    logic                     busy_o;
    logic [1:0]               active_evt_o;
    logic                     done_o;
    logic                     dropped_o;

    always #5 tb_clk = ~tb_clk;

    sfx_tone_gen #(
        .NUM_EVT     (NUM_EVT),
        .DIV_W       (DIV_W),
        .DUR_W       (DUR_W),
        .SWEEP_SHIFT (SWEEP_SHIFT)
    ) dut (
        .clk          (tb_clk),
        .rst          (rst),
        .evt_i        (evt_i),
        .period_i     (period_i),
        .dur_i        (dur_i),
        .sweep_i      (sweep_i),
        .square_o     (square_o),
        .at_max_o     (at_max_o),
        .busy_o       (busy_o),
        .active_evt_o (active_evt_o),
        .done_o       (done_o),
        .dropped_o    (dropped_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a burst is described by its start, period and length;
    // outputs follow from the elapsed cycle count m_t.
    logic [NUM_EVT-1:0] m_prev = '0;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_drop = 1'b0;
    int m_t = 0, m_p = 2, m_d = 1, m_idx = 0;

    // Per-run statistics
    int  st_busy, st_atmax, st_tog, st_drop, st_done, st_starts, st_idx;
    bit  prev_sq, prev_busy;

    typedef struct {
        string                    name;
        logic [NUM_EVT-1:0]       evt;
        logic [NUM_EVT*DIV_W-1:0] per;
        logic [NUM_EVT*DUR_W-1:0] dur;
        int                       hold;
        int                       exp_idx;
        int                       exp_busy;
        int                       exp_atmax;
        int                       exp_tog;
        int                       exp_drop;
        int                       exp_done;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    function automatic int get_period(input int k);
        return int'(period_i[k*DIV_W +: DIV_W]);
    endfunction

    function automatic int get_dur(input int k);
        return int'(dur_i[k*DUR_W +: DUR_W]);
    endfunction

    task automatic model_reset();
        m_prev = '0; m_busy = 1'b0; m_done = 1'b0; m_drop = 1'b0;
        m_t = 0; m_p = 2; m_d = 1; m_idx = 0;
    endtask

    task automatic model_edge();
        logic [NUM_EVT-1:0] trig;
        int  first, n;
        bit  ending;
        trig   = evt_i & ~m_prev;
        m_prev = evt_i;
        first  = -1;
        n      = 0;
        for (int k = 0; k < NUM_EVT; k++) begin
            if (trig[k]) begin
                n++;
                if (first < 0) first = k;
            end
        end
        m_done = 1'b0;
        m_drop = (n > 1);
        ending = m_busy && (m_t == m_p * m_d - 1);
        if (first >= 0 && (!m_busy || first <= m_idx)) begin
            m_busy = 1'b1;
            m_t    = 0;
            m_idx  = first;
            m_p    = get_period(first);
            if (m_p < 2) m_p = 2;
            m_d    = get_dur(first);
            if (m_d < 1) m_d = 1;
        end else begin
            if (first >= 0) m_drop = 1'b1;
            if (m_busy) begin
                if (ending) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_idx  = 0;
                end else begin
                    m_t++;
                end
            end
        end
    endtask

    task automatic compare_outputs();
        chk("busy",       int'(busy_o),       int'(m_busy));
        chk("active_evt", int'(active_evt_o), m_busy ? m_idx : 0);
        chk("square",     int'(square_o),     m_busy ? ((m_t / m_p) % 2) : 0);
        chk("at_max",     int'(at_max_o),     (m_busy && (m_t % m_p == m_p - 1)) ? 1 : 0);
        chk("done",       int'(done_o),       int'(m_done));
        chk("dropped",    int'(dropped_o),    int'(m_drop));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_square"},  int'(square_o),     0);
        chk({tag, "_at_max"},  int'(at_max_o),     0);
        chk({tag, "_busy"},    int'(busy_o),       0);
        chk({tag, "_active"},  int'(active_evt_o), 0);
        chk({tag, "_done"},    int'(done_o),       0);
        chk({tag, "_dropped"}, int'(dropped_o),    0);
    endtask

    task automatic clear_stats();
        st_busy = 0; st_atmax = 0; st_tog = 0; st_drop = 0;
        st_done = 0; st_starts = 0; st_idx = -1;
        prev_sq = square_o; prev_busy = busy_o;
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge.
    task automatic tick();
        @(posedge tb_clk);
        model_edge();
        @(negedge tb_clk);
        cyc++;
        compare_outputs();
        st_busy  += int'(busy_o);
        st_atmax += int'(at_max_o);
        st_done  += int'(done_o);
        st_drop  += int'(dropped_o);
        if (square_o != prev_sq) st_tog++;
        if (busy_o && !prev_busy) begin
            st_starts++;
            if (st_idx < 0) st_idx = int'(active_evt_o);
        end
        prev_sq   = square_o;
        prev_busy = busy_o;
    endtask

    task automatic run_to_idle(input string name);
        int guard;
        guard = 0;
        while (busy_o && guard < 2000) begin
            tick();
            guard++;
        end
        if (guard >= 2000) chk({name, "_timeout"}, 1, 0);
        tick();
    endtask

    function automatic logic [NUM_EVT*DIV_W-1:0] pk_per(input int p3, input int p2, input int p1, input int p0);
        return {DIV_W'(p3), DIV_W'(p2), DIV_W'(p1), DIV_W'(p0)};
    endfunction

    function automatic logic [NUM_EVT*DUR_W-1:0] pk_dur(input int d3, input int d2, input int d1, input int d0);
        return {DUR_W'(d3), DUR_W'(d2), DUR_W'(d1), DUR_W'(d0)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        //                name        evt      periods (3,2,1,0)       durs (3,2,1,0)     hold idx busy atm tog drp done
        vecs[0] = '{"basic",    4'b0100, pk_per(0, 4, 0, 0),  pk_dur(0, 6, 0, 0), 5, 2, 24, 6, 6, 0, 1};
        vecs[1] = '{"simul",    4'b0110, pk_per(0, 4, 3, 0),  pk_dur(0, 6, 5, 0), 2, 1, 15, 5, 4, 1, 1};
        vecs[2] = '{"zero_par", 4'b1000, pk_per(0, 9, 9, 9),  pk_dur(0, 9, 9, 9), 1, 3,  2, 1, 0, 0, 1};
        vecs[3] = '{"per_one",  4'b0001, pk_per(9, 9, 9, 1),  pk_dur(9, 9, 9, 2), 3, 0,  4, 2, 2, 0, 1};
        vecs[4] = '{"all_four", 4'b1111, pk_per(2, 2, 2, 5),  pk_dur(2, 2, 2, 3), 4, 0, 15, 3, 2, 1, 1};
        vecs[5] = '{"single",   4'b0010, pk_per(0, 0, 7, 0),  pk_dur(0, 0, 1, 0), 2, 1,  7, 1, 0, 0, 1};

        rst = 1'b1; evt_i = '0; period_i = '0; dur_i = '0; sweep_i = '0;
        repeat (2) @(negedge tb_clk);
        check_all_zero("reset");
        rst = 1'b0;
        model_reset();
        repeat (2) tick();

        // Table-driven single bursts
        foreach (vecs[i]) begin
            period_i = vecs[i].per;
            dur_i    = vecs[i].dur;
            clear_stats();
            evt_i    = vecs[i].evt;
            repeat (vecs[i].hold) tick();
            evt_i    = '0;
            run_to_idle(vecs[i].name);
            chk({vecs[i].name, "_idx"},    st_idx,   vecs[i].exp_idx);
            chk({vecs[i].name, "_busy"},   st_busy,  vecs[i].exp_busy);
            chk({vecs[i].name, "_atmax"},  st_atmax, vecs[i].exp_atmax);
            chk({vecs[i].name, "_toggle"}, st_tog,   vecs[i].exp_tog);
            chk({vecs[i].name, "_drop"},   st_drop,  vecs[i].exp_drop);
            chk({vecs[i].name, "_done"},   st_done,  vecs[i].exp_done);
            tick();
        end

        // Preemption: event 2 interrupted by event 0, then event 3 discarded
        period_i = pk_per(5, 10, 0, 3);
        dur_i    = pk_dur(2, 8, 0, 4);
        clear_stats();
        evt_i = 4'b0100;
        repeat (25) tick();
        evt_i = 4'b0101;
        tick();
        chk("preempt_active", int'(active_evt_o), 0);
        repeat (3) tick();
        evt_i = 4'b1101;
        tick();
        chk("preempt_drop_pulse", int'(dropped_o), 1);
        evt_i = '0;
        run_to_idle("preempt");
        chk("preempt_busy",  st_busy, 25 + 12);
        chk("preempt_done",  st_done, 1);
        chk("preempt_drops", st_drop, 1);
        tick();

        // Asynchronous reset in the middle of a burst with event 2 held high
        period_i = pk_per(0, 10, 0, 0);
        dur_i    = pk_dur(0, 8, 0, 0);
        evt_i    = 4'b0100;
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        model_reset();
        repeat (2) @(negedge tb_clk);
        check_all_zero("inrst");
        rst = 1'b0;
        clear_stats();
        repeat (100) tick();
        chk("rst_release_starts", st_starts, 1);
        chk("rst_release_idx",    st_idx,    2);
        chk("rst_release_busy",   st_busy,   80);
        chk("rst_release_done",   st_done,   1);
        evt_i = '0;
        repeat (2) tick();

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 7) == 0) evt_i[$urandom_range(0, NUM_EVT - 1)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) begin
                for (int k = 0; k < NUM_EVT; k++) begin
                    period_i[k*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 6));
                    dur_i[k*DUR_W +: DUR_W]    = DUR_W'($urandom_range(0, 4));
                end
            end
`ifdef SFX_SWEEP_EN
            sweep_i = '0;
`else
            sweep_i = NUM_EVT'($urandom_range(0, 15));
`endif
            tick();
        end
        evt_i = '0;
        run_to_idle("random");

`ifdef SFX_SWEEP_EN
        // Sweep: at_max spacing grows 16, 18, 20
        begin
            int t_at[$];
            int guard;
            int bcnt;
            repeat (3) @(negedge tb_clk);
            period_i = pk_per(0, 0, 0, 16);
            dur_i    = pk_dur(0, 0, 0, 3);
            sweep_i  = 4'b0001;
            evt_i    = 4'b0001;
            guard    = 0;
            bcnt     = 0;
            @(negedge tb_clk);
            evt_i = '0;
            while (busy_o && guard < 500) begin
                guard++;
                bcnt++;
                if (at_max_o) t_at.push_back(guard);
                @(negedge tb_clk);
            end
            chk("sweep_busy",   bcnt, 16 + 18 + 20);
            chk("sweep_n_at",   t_at.size(), 3);
            if (t_at.size() == 3) begin
                chk("sweep_gap0", t_at[0], 16);
                chk("sweep_gap1", t_at[1] - t_at[0], 18);
                chk("sweep_gap2", t_at[2] - t_at[1], 20);
            end
            chk("sweep_done", int'(done_o), 1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sfx_tone_gen.md
# sfx_tone_gen

Multi-channel sound-effect tone generator for the snake game audio path, successor to the single-purpose collision oscillator. It accepts NUM_EVT event lines (good collision, bad collision, food, game over, …) and edge-detects them. It arbitrates by fixed priority and plays one square-wave tone burst whose period and length are set per event. It drives the speaker pin and exposes at_max ticks, busy/done status and the active event index to the game FSM.

## Interface
- NUM_EVT, 4: number of event channels, 2..8.
- DIV_W, 16: width of tone half-period counter and period inputs.
- DUR_W, 12: width of duration (half-period count) inputs.
- SWEEP_SHIFT, 3: sweep step shift, used only with SFX_SWEEP_EN.
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- evt_i  in  NUM_EVT  event request levels; a 0→1 transition triggers.
- period_i  in  NUM_EVT*DIV_W  per-event half-period in clk cycles; slice k = event k.
- dur_i  in  NUM_EVT*DUR_W  per-event burst length in half-periods.
- sweep_i  in  NUM_EVT  per-event pitch-sweep enable.
- square_o  out  1  tone output to speaker.
- at_max_o  out  1  one-cycle tick when the half-period counter reaches its terminal count.
- busy_o  out  1  tone playing.
- active_evt_o  out  $clog2(NUM_EVT)  index of playing event; 0 when idle.
- done_o  out  1  one-cycle pulse when a burst completes normally.
- dropped_o  out  1  one-cycle pulse when any trigger is discarded.

## Operation
- Edge detect: evt_q registers evt_i. trig[k] = evt_i[k] & ~evt_q[k]. A level held for many cycles gives exactly one trigger.
- Arbitration: the lowest index wins among simultaneous triggers. Losing triggers pulse dropped_o.
- States IDLE and PLAY.
  - IDLE→PLAY on any trig.
  - PLAY→PLAY restart on a trig with index ≤ active index. Preemption or retrigger reloads everything. done_o is not pulsed for the aborted burst.
  - PLAY→IDLE when at_max fires with dur_rem == 1.
  - A trig with index > active index during PLAY is dropped.
- Load on start: cnt←0, square←0.
  - period_q←max(period_i[k], 2).
  - dur_rem←max(dur_i[k], 1).
  - sweep_q←sweep_i[k].
  - active_evt←k.
- In PLAY, at_max_o = (cnt == period_q−1), combinational from registers.
  - On that edge: cnt←0, square toggles, dur_rem decrements.
  - Otherwise cnt increments.
- Burst length is exactly period_q·dur cycles of busy_o when no sweep is active.
- On exit: square_o←0, active_evt←0, done_o pulses on the following cycle.

## Timing
- All outputs reset to 0. evt_q also resets to 0, so a line held high through reset release triggers once.
- Trigger latency: trig sampled at posedge T makes busy_o high and active_evt_o valid after T.
- First at_max_o occurs period_q cycles after the start edge.
- Reset mid-burst: state goes to IDLE immediately and asynchronously. All outputs clear. No done_o pulse.
- Inputs period_i, dur_i and sweep_i are sampled only at a start edge. Later changes do not affect the burst in progress.

## Configuration
- SFX_SWEEP_EN defined: on each at_max during PLAY with sweep_q=1, period_q ← period_q + max(period_q>>SWEEP_SHIFT, 1). The sum saturates at 2^DIV_W−1. This gives a falling pitch for bad collision / game over.
- SFX_SWEEP_EN undefined: the sweep logic is absent, sweep_i is ignored and period_q is constant for the whole burst.

## Structure
- Package sfx_pkg holds:
  - state enum sfx_state_t {IDLE, PLAY};
  - event index constants EVT_BAD=0, EVT_GAMEOVER=1, EVT_GOOD=2, EVT_FOOD=3;
  - default tone constants per event.
- Sub-module sfx_evt_arb contains the edge-detect registers, priority encoder, dropped generation and trig/index outputs. The top contains the FSM, counters and sweep logic.

## Test plan
- Reset: assert rst mid-cycle with evt_i[2]=1 → all outputs 0 during reset. After release, exactly one burst for event 2.
- Basic burst: event 2 with period 4, dur 6, held high 5 cycles → at_max_o every 4 cycles, square_o toggles 6 times, busy_o exactly 24 cycles, done_o one pulse, no dropped_o.
- Simultaneous triggers: evt_i=4'b0110 rising together → active_evt_o=1, dropped_o one pulse, burst uses event-1 period and duration.
- Preemption: event 2 playing (period 10, dur 8). Trigger event 0 at cycle 25 → restarts with event-0 parameters, active_evt_o=0, no done_o for event 2. A trigger on event 3 during the event-0 burst → dropped_o pulse, burst unaffected.
- Boundaries: period 0 behaves as period 2 and dur 0 as dur 1 → busy_o 2 cycles, one at_max_o, done_o.
- Sweep (SFX_SWEEP_EN): period 16, dur 3, sweep=1, SWEEP_SHIFT=3 → at_max spacing 16, 18, 20 cycles. Period 2^DIV_W−2 saturates at 2^DIV_W−1.
